// File: rtl/pool_max_pkg.sv
// Shared pooling definitions: frame FSM encoding and a signed max helper.
package pool_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } pool_state_e;

  // Operands are sign-extended to this width by the caller, so one
  // function serves any activation width up to CMP_W.
  localparam int CMP_W = 64;

  function automatic logic signed [CMP_W-1:0] smax(
    input logic signed [CMP_W-1:0] a,
    input logic signed [CMP_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_max_line_buf.sv
// Row buffer of pair maxima: simple dual-port RAM with a registered,
// enabled read so it maps onto block RAM.
module pool_line_buf #(
  parameter int NUM_WIDTH = 16,
  parameter int DEPTH     = 128,
  parameter int AW        = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [NUM_WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [NUM_WIDTH-1:0] rdata
);

  logic [NUM_WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read; rdata holds until the next read enable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool_max.sv
// Streaming 2x2 stride-2 max pool with a 1:1 bypass mode.
module pool_max
  import pool_max_pkg::*;
#(
  parameter int NUM_WIDTH = 16,
  parameter int ROW_MAX   = 256,
  parameter int ROW_AW    = $clog2(ROW_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bypass,
  input  logic [ROW_AW:0]      row_width,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  input  logic                 up_last,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_last,
  output logic                 frame_err
);

  localparam int LB_AW    = ROW_AW - 1;
  localparam int LB_DEPTH = ROW_MAX / 2;
  localparam logic [ROW_AW:0]   ONE_W = 1;
  localparam logic [ROW_AW-1:0] ONE_C = 1;

  function automatic logic [NUM_WIDTH-1:0] max_s(
    input logic [NUM_WIDTH-1:0] a,
    input logic [NUM_WIDTH-1:0] b
  );
    return NUM_WIDTH'(smax(CMP_W'(signed'(a)), CMP_W'(signed'(b))));
  endfunction

  pool_state_e          state, state_nxt;
  logic [ROW_AW-1:0]    col, col_nxt;
  logic [ROW_AW:0]      width_q;
  logic                 byp_q;
  logic [NUM_WIDTH-1:0] pair_reg;
  logic [NUM_WIDTH-1:0] lb_rdata;

  logic                 accept, first, cur_byp, odd_row, row_end, last_ok;
  logic [ROW_AW:0]      cur_w, col_x, last_odd_col;
  logic [NUM_WIDTH-1:0] pair_max, pool_out, out_data;
  logic                 produce, out_last, err, lb_we, lb_re;

  assign up_ready = !dn_valid || dn_ready;
  assign accept   = up_valid && up_ready;

  // The first beat of a frame uses the live mode/width inputs; later beats
  // use the values latched from that beat.
  assign first   = (state == ST_IDLE);
  assign cur_byp = first ? bypass : byp_q;
  assign cur_w   = first ? row_width : width_q;
  assign odd_row = (state == ST_ODD);
  assign col_x   = {1'b0, col};
  assign row_end = (col_x == cur_w - ONE_W);

  // Odd column of the last complete pair; for odd widths this is w-2.
  assign last_odd_col = {cur_w[ROW_AW:1], 1'b0} - ONE_W;
  assign last_ok      = odd_row && col[0] && (col_x == last_odd_col);

  assign pair_max = max_s(pair_reg, up_data);
  assign pool_out = max_s(pair_max, lb_rdata);

  // Next-state and per-beat control decode.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    produce   = 1'b0;
    out_data  = up_data;
    out_last  = up_last;
    err       = 1'b0;
    lb_we     = 1'b0;
    lb_re     = 1'b0;
    if (accept) begin
      if (cur_byp) begin
        produce   = 1'b1;
        state_nxt = up_last ? ST_IDLE : ST_EVEN;
        col_nxt   = '0;
      end else if (up_last && !last_ok) begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
        col_nxt   = '0;
      end else begin
        if (!col[0]) begin
          lb_re = odd_row;
        end else if (odd_row) begin
          produce  = 1'b1;
          out_data = pool_out;
        end else begin
          lb_we = 1'b1;
        end
        if (up_last) begin
          state_nxt = ST_IDLE;
          col_nxt   = '0;
        end else if (row_end) begin
          col_nxt   = '0;
          state_nxt = odd_row ? ST_EVEN : ST_ODD;
        end else begin
          col_nxt   = col + ONE_C;
          state_nxt = odd_row ? ST_ODD : ST_EVEN;
        end
      end
    end
  end

  // FSM state and column counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      col   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
    end
  end

  // Per-frame mode and width, captured on the frame's first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q   <= 1'b0;
      width_q <= '0;
    end else if (accept && first) begin
      byp_q   <= bypass;
      width_q <= row_width;
    end
  end

  // Even-column pixel waits here for its odd-column partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                pair_reg <= '0;
    else if (accept && !cur_byp && !col[0]) pair_reg <= up_data;
  end

  // Single output register; holds while the writer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid  <= 1'b0;
      dn_data   <= '0;
      dn_last   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (produce) begin
        dn_valid <= 1'b1;
        dn_data  <= out_data;
        dn_last  <= out_last;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

  pool_line_buf #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEPTH     (LB_DEPTH),
    .AW        (LB_AW)
  ) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col[ROW_AW-1:1]),
    .wdata (pair_max),
    .re    (lb_re),
    .raddr (col[ROW_AW-1:1]),
    .rdata (lb_rdata)
  );

endmodule

// File: tb/tb_pool_max.sv
// Directed bench for pool_max with an output scoreboard.
module tb_pool_max;

  localparam int NW = 16;
  localparam int RM = 16;
  localparam int RA = 4;

  logic          clk = 1'b0;
  logic          rst, bypass, up_valid, up_ready, up_last;
  logic [RA:0]   row_width;
  logic [NW-1:0] up_data, dn_data;
  logic          dn_valid, dn_ready, dn_last, frame_err;

  typedef struct packed { logic [NW-1:0] d; logic l; } exp_t;
  exp_t sb[$];

  int pix [256];
  int n_cmp = 0, n_err = 0, err_pulses = 0, err_base;
  bit bp_mode = 0, gap_mode = 0, chk_lat = 0;
  bit hold_chk = 0;
  logic [NW-1:0] hold_d;
  logic          hold_l;

  always #5 clk = ~clk;

  pool_max #(.NUM_WIDTH(NW), .ROW_MAX(RM), .ROW_AW(RA)) dut (
    .clk(clk), .rst(rst), .bypass(bypass), .row_width(row_width),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_last(up_last),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_last(dn_last),
    .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", {31'd0, dn_valid}, 32'd1);
        check("hold_data", {15'd0, dn_last, dn_data}, {15'd0, hold_l, hold_d});
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_out: observed data %0d last %0d expected no output", dn_data, dn_last);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out", {15'd0, dn_last, dn_data}, {15'd0, e.l, e.d});
        end
      end
      hold_chk = dn_valid && !dn_ready;
      hold_d   = dn_data;
      hold_l   = dn_last;
      if (frame_err === 1'b1) err_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dn_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push(input int v, input bit l);
    exp_t e;
    e.d = NW'(v);
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [NW-1:0] d, input logic l);
    bit got;
    int t;
    got = 0;
    t = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    while (!got && t < 200) begin
      @(negedge clk);
      got = up_ready;
      tick();
      t++;
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout: observed no accept expected accept of %0d", d);
    end
    if (chk_lat) begin
      check("lat_valid", {31'd0, dn_valid}, 32'd1);
      check("lat_data", {15'd0, dn_last, dn_data}, {15'd0, l, d});
    end
    if (gap_mode) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_frame(input int w, input int h, input bit mark_last);
    for (int i = 0; i < w * h; i++) send(NW'(pix[i]), mark_last && (i == w * h - 1));
  endtask

  // Reference: plain 2D max over each complete 2x2 window.
  task automatic push_pool(input int w, input int h);
    for (int r = 0; r + 1 < h; r += 2)
      for (int c = 0; c + 1 < w; c += 2) begin
        int m;
        m = pix[r*w+c];
        if (pix[r*w+c+1] > m)     m = pix[r*w+c+1];
        if (pix[(r+1)*w+c] > m)   m = pix[(r+1)*w+c];
        if (pix[(r+1)*w+c+1] > m) m = pix[(r+1)*w+c+1];
        push(m, (r + 4 > h) && (c + 4 > w));
      end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || dn_valid) && t < 500) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic basic_frame(input string tag);
    for (int i = 0; i < 16; i++) pix[i] = i;
    row_width = 5'd4;
    err_base  = err_pulses;
    push(5, 0); push(7, 0); push(13, 0); push(15, 1);
    send_frame(4, 4, 1);
    drain();
    check({tag, "_err"}, err_pulses - err_base, 32'd0);
  endtask

  initial begin
    rst = 1'b0; bypass = 1'b0; row_width = 5'd4;
    up_valid = 1'b0; up_data = '0; up_last = 1'b0; dn_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, dn_valid}, 32'd0);
    check("rst_data", {16'd0, dn_data}, 32'd0);
    check("rst_last", {31'd0, dn_last}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_ready", {31'd0, up_ready}, 32'd1);
    rst = 1'b0;
    tick();

    basic_frame("basic");

    // Signed compare on a single 2x2 window.
    pix[0] = -3; pix[1] = -1; pix[2] = -7; pix[3] = -2;
    row_width = 5'd2;
    push(-1, 1);
    send_frame(2, 2, 1);
    drain();

    // Backpressure and gapped input.
    bp_mode = 1; gap_mode = 1;
    basic_frame("bp");
    bp_mode = 0; gap_mode = 0; dn_ready = 1'b1;

    // Bypass: 1:1, one cycle after acceptance.
    bypass = 1'b1; chk_lat = 1;
    pix[0] = -5; pix[1] = 2; pix[2] = 0; pix[3] = 9; pix[4] = -1; pix[5] = 4;
    for (int i = 0; i < 6; i++) push(pix[i], i == 5);
    err_base = err_pulses;
    send_frame(6, 1, 1);
    drain();
    check("byp_err", err_pulses - err_base, 32'd0);
    bypass = 1'b0; chk_lat = 0;

    // Misplaced up_last on row 0 col 3: dropped, single error pulse.
    for (int i = 0; i < 4; i++) pix[i] = i;
    row_width = 5'd4;
    err_base  = err_pulses;
    send_frame(4, 1, 1);
    drain();
    check("misplaced_err", err_pulses - err_base, 32'd1);
    basic_frame("after_err");

    // Full-width rows with random signed data under backpressure.
    for (int i = 0; i < 2 * RM; i++) pix[i] = $urandom_range(0, 2000) - 1000;
    row_width = 5'(RM);
    push_pool(RM, 2);
    bp_mode = 1;
    send_frame(RM, 2, 1);
    drain();
    bp_mode = 0; dn_ready = 1'b1;

    // Odd width: columns 4 and 9 fall out, then reset lands mid-row.
    for (int i = 0; i < 12; i++) pix[i] = i;
    row_width = 5'd5;
    push(6, 0); push(8, 0);
    send_frame(5, 2, 0);
    drain();
    send(NW'(10), 1'b0);
    send(NW'(11), 1'b0);
    check("pre_rst_data", {16'd0, dn_data}, 32'd8);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, dn_valid}, 32'd0);
    check("mid_rst_data", {16'd0, dn_data}, 32'd0);
    check("mid_rst_last", {31'd0, dn_last}, 32'd0);
    check("mid_rst_err", {31'd0, frame_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    basic_frame("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
